flashrom_boot_loader: RTL and testbench
=======================================

# flashrom_boot_loader

Boot sequencer that sits directly downstream of the instruction flash ROM. After reset it walks the ROM address space from word 0 and registers each 16-bit instruction. It then writes each instruction into core instruction memory over a valid/ready handshake, holding the core in reset until the image is fully copied. It also produces an XOR checksum of the copied image for boot diagnostics.

## Interface
Parameters:
- ADDRWIDTH, 10, ROM/instruction-memory word address width.
- DATAWIDTH, 16, instruction width.
- BOOTLENGTH, 16, number of words copied; legal range 1..2^ADDRWIDTH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, reset asynchronous and active-low.
- BootRequest  in  1  single-cycle pulse; restarts the copy when in DONE, ignored otherwise.
- ROMAddress  out  ADDRWIDTH  address driven to the combinational ROM.
- ROMValue  in  DATAWIDTH  ROM output for ROMAddress, valid in the same cycle.
- WriteValid  out  1  write request to instruction memory.
- WriteAddress  out  ADDRWIDTH  target word address; equals source ROM address.
- WriteData  out  DATAWIDTH  instruction word.
- WriteReady  in  1  instruction memory accepts when WriteValid && WriteReady.
- BootBusy  out  1  copy in progress.
- BootDone  out  1  image copied; level.
- CoreHold  out  1  holds the core in reset; equals !BootDone.
- Checksum  out  DATAWIDTH  XOR of all words written; final when BootDone=1.

## Operation
- States: FETCH, DRAIN, DONE. Reset enters FETCH with the read counter at 0.
- The output stage is a one-entry register holding WriteValid, WriteAddress, and WriteData. It is "free" when WriteValid=0 or when a handshake occurs this cycle.
- FETCH:
  - ROMAddress = read counter.
  - When the output stage is free, capture {counter, ROMValue} and set WriteValid=1.
  - If counter == BOOTLENGTH-1, go to DRAIN; otherwise increment the counter.
  - When the stage is not free, the counter and ROMAddress hold.
- DRAIN: no new fetch. On the final handshake, clear WriteValid and go to DONE.
- DONE:
  - BootDone=1, CoreHold=0, BootBusy=0, WriteValid=0.
  - BootRequest=1 clears Checksum, resets the counter to 0, and enters FETCH.
- Checksum ^= WriteData on every handshake, and only on handshakes.
- WriteData and WriteAddress must stay stable while WriteValid=1 && WriteReady=0.
- The counter never wraps. BOOTLENGTH = 2^ADDRWIDTH ends at address all-ones without overflow into 0.
- BOOTLENGTH=1: FETCH lasts one cycle, then DRAIN.
- BootRequest in FETCH or DRAIN: ignored, with no effect on the counter or checksum.
- Reset asserted mid-copy: immediately aborts the copy and returns all outputs to their reset values; the copy restarts from word 0 after release.

## Timing
- Reset values:
  - ROMAddress=0, WriteValid=0, WriteAddress=0, WriteData=0.
  - BootBusy=1, BootDone=0, CoreHold=1, Checksum=0.
- Latency: ROM word k appears on WriteData one cycle after ROMAddress=k is presented with the stage free.
- With WriteReady held high, throughput is one word per cycle:
  - first WriteValid in cycle 1 after reset release;
  - last handshake in cycle BOOTLENGTH;
  - BootDone=1 in cycle BOOTLENGTH+1.
- Back-pressure: each cycle of WriteReady=0 with WriteValid=1 adds exactly one cycle.
- BootRequest in DONE: BootDone falls and BootBusy rises on the next edge. The first new WriteValid follows one cycle later.
- All outputs are registered except ROMAddress, which is a direct counter output.

## Structure
- Package flashrom_boot_pkg holds:
  - the state enum (FETCH, DRAIN, DONE);
  - default ADDRWIDTH/DATAWIDTH constants, shared with the ROM and instruction memory.
- One natural sub-module, boot_write_stage: the one-entry valid/ready output register with load/hold/clear. The FSM, counter, and checksum stay in the top.

## Test plan
Stub ROM: Value = Address ^ 16'hA5A5.
- Default BOOTLENGTH=16, WriteReady=1 → 16 handshakes, addresses 0..15 in order, data A5A5..A5AA; BootDone=1 at cycle 17; Checksum=16'h0000.
- BOOTLENGTH=3, WriteReady=1 → data A5A5, A5A4, A5A7; Checksum=16'hA5A6; CoreHold falls in cycle 4.
- BOOTLENGTH=3, WriteReady low on cycles 2–4 → WriteAddress=1 and WriteData=A5A4 held stable throughout; BootDone at cycle 7; Checksum still A5A6.
- Assert rst_n=0 after 5 handshakes, then release → outputs at reset values; the copy restarts at address 0 and completes normally.
- BootRequest pulsed during FETCH → ignored; BootRequest pulsed in DONE → full second copy with an identical checksum; BootDone low for the duration.
- BOOTLENGTH=1024 → last WriteAddress=10'h3FF; no wrap to 0; BootDone at cycle 1025.

Source files
------------

// File: rtl/flashrom_boot_pkg.sv
// Shared types and default widths for the flash-ROM boot path.
// The same widths are used by the ROM, the instruction memory and the boot loader.
package flashrom_boot_pkg;

  localparam int DEF_ADDRWIDTH = 10;
  localparam int DEF_DATAWIDTH = 16;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } boot_state_e;

endpackage

// File: rtl/flashrom_boot_loader_write_stage.sv
// One-entry valid/ready output register feeding instruction memory.
// Loading has priority over clearing, so the entry can turn over back-to-back.
module boot_write_stage
  import flashrom_boot_pkg::*;
#(
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int DATAWIDTH = DEF_DATAWIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 ready,
  input  logic [ADDRWIDTH-1:0] addr_in,
  input  logic [DATAWIDTH-1:0] data_in,
  output logic                 valid,
  output logic [ADDRWIDTH-1:0] addr,
  output logic [DATAWIDTH-1:0] data,
  output logic                 free,
  output logic                 fire
);

  logic                 valid_q, valid_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0] data_q, data_d;

  assign fire = valid_q & ready;
  assign free = ~valid_q | ready;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      addr_d  = addr_in;
      data_d  = data_in;
    end else if (fire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign addr  = addr_q;
  assign data  = data_q;

endmodule

// File: rtl/flashrom_boot_loader.sv
// Copies the first BOOTLENGTH words of the instruction flash ROM into core
// instruction memory, holding the core in reset and XOR-summing the image.
module flashrom_boot_loader
  import flashrom_boot_pkg::*;
#(
  parameter int ADDRWIDTH  = DEF_ADDRWIDTH,
  parameter int DATAWIDTH  = DEF_DATAWIDTH,
  parameter int BOOTLENGTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 BootRequest,
  output logic [ADDRWIDTH-1:0] ROMAddress,
  input  logic [DATAWIDTH-1:0] ROMValue,
  output logic                 WriteValid,
  output logic [ADDRWIDTH-1:0] WriteAddress,
  output logic [DATAWIDTH-1:0] WriteData,
  input  logic                 WriteReady,
  output logic                 BootBusy,
  output logic                 BootDone,
  output logic                 CoreHold,
  output logic [DATAWIDTH-1:0] Checksum
);

  // Last address is computed in 32 bits first so BOOTLENGTH = 2^ADDRWIDTH maps to all-ones.
  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(BOOTLENGTH - 1);

  boot_state_e          state_q, state_d;
  logic [ADDRWIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [DATAWIDTH-1:0] sum_q, sum_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 hold_q, hold_d;
  logic                 stage_free, stage_fire, stage_load;

  assign stage_load = (state_q == FETCH) && stage_free;

  boot_write_stage #(
    .ADDRWIDTH(ADDRWIDTH),
    .DATAWIDTH(DATAWIDTH)
  ) u_write_stage (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (stage_load),
    .ready  (WriteReady),
    .addr_in(rd_cnt_q),
    .data_in(ROMValue),
    .valid  (WriteValid),
    .addr   (WriteAddress),
    .data   (WriteData),
    .free   (stage_free),
    .fire   (stage_fire)
  );

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    sum_d    = sum_q;
    busy_d   = busy_q;
    done_d   = done_q;
    hold_d   = hold_q;
    if (stage_fire) begin
      sum_d = sum_q ^ WriteData;
    end
    case (state_q)
      FETCH: begin
        if (stage_free) begin
          if (rd_cnt_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            rd_cnt_d = rd_cnt_q + ADDRWIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (stage_fire) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hold_d  = 1'b0;
        end
      end
      DONE: begin
        if (BootRequest) begin
          state_d  = FETCH;
          rd_cnt_d = '0;
          sum_d    = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          hold_d   = 1'b1;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      rd_cnt_q <= '0;
      sum_q    <= '0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      hold_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      sum_q    <= sum_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hold_q   <= hold_d;
    end
  end

  assign ROMAddress = rd_cnt_q;
  assign BootBusy   = busy_q;
  assign BootDone   = done_q;
  assign CoreHold   = hold_q;
  assign Checksum   = sum_q;

endmodule

// File: tb/tb_flashrom_boot_loader.sv
// Directed bench for flashrom_boot_loader with three image lengths (16, 3, 1024)
// and a scoreboard of expected {address, data} writes.
module tb_flashrom_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        boot_req;
  logic [9:0]  rom_addr [3];
  logic [15:0] rom_val  [3];
  logic        wv       [3];
  logic [9:0]  wa       [3];
  logic [15:0] wd       [3];
  logic        wr       [3];
  logic        busy     [3];
  logic        done     [3];
  logic        hold     [3];
  logic [15:0] csum     [3];

  int checks = 0;
  int errors = 0;
  int sel, cyc, hs_cnt, first_valid, done_cyc, hold_fall, req_cyc, stall_lo, stall_hi;
  logic [9:0]  last_addr;
  logic [25:0] exp_q[$];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rom
      assign rom_val[gi] = {6'b0, rom_addr[gi]} ^ 16'hA5A5;
    end
  endgenerate

  flashrom_boot_loader #(.ADDRWIDTH(10), .DATAWIDTH(16), .BOOTLENGTH(16)) u_bl16 (
    .clk(clk), .rst_n(rst_n), .BootRequest(boot_req),
    .ROMAddress(rom_addr[0]), .ROMValue(rom_val[0]),
    .WriteValid(wv[0]), .WriteAddress(wa[0]), .WriteData(wd[0]), .WriteReady(wr[0]),
    .BootBusy(busy[0]), .BootDone(done[0]), .CoreHold(hold[0]), .Checksum(csum[0]));

  flashrom_boot_loader #(.ADDRWIDTH(10), .DATAWIDTH(16), .BOOTLENGTH(3)) u_bl3 (
    .clk(clk), .rst_n(rst_n), .BootRequest(boot_req),
    .ROMAddress(rom_addr[1]), .ROMValue(rom_val[1]),
    .WriteValid(wv[1]), .WriteAddress(wa[1]), .WriteData(wd[1]), .WriteReady(wr[1]),
    .BootBusy(busy[1]), .BootDone(done[1]), .CoreHold(hold[1]), .Checksum(csum[1]));

  flashrom_boot_loader #(.ADDRWIDTH(10), .DATAWIDTH(16), .BOOTLENGTH(1024)) u_bl1k (
    .clk(clk), .rst_n(rst_n), .BootRequest(boot_req),
    .ROMAddress(rom_addr[2]), .ROMValue(rom_val[2]),
    .WriteValid(wv[2]), .WriteAddress(wa[2]), .WriteData(wd[2]), .WriteReady(wr[2]),
    .BootBusy(busy[2]), .BootDone(done[2]), .CoreHold(hold[2]), .Checksum(csum[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] model_sum(input int n);
    logic [15:0] s = '0;
    for (int k = 0; k < n; k++) s = s ^ (16'(k) ^ 16'hA5A5);
    return s;
  endfunction

  task automatic push_copy(input int n);
    for (int k = 0; k < n; k++) begin
      logic [9:0]  a = k[9:0];
      logic [15:0] d = 16'(k) ^ 16'hA5A5;
      exp_q.push_back({a, d});
    end
  endtask

  // One clock: inputs change 1ns after the edge, outputs are sampled on the falling edge.
  task automatic step();
    logic [25:0] e;
    @(posedge clk);
    cyc++;
    #1;
    boot_req = (cyc == req_cyc);
    wr[sel]  = !(cyc >= stall_lo && cyc <= stall_hi);
    @(negedge clk);
    if (wv[sel] && first_valid < 0) first_valid = cyc;
    if (done[sel] && done_cyc < 0) done_cyc = cyc;
    if (!hold[sel] && hold_fall < 0) hold_fall = cyc;
    if (wv[sel] && wr[sel]) begin
      hs_cnt++;
      last_addr = wa[sel];
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL extra_write: observed addr %h data %h expected no write", wa[sel], wd[sel]);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_addr_data", {6'b0, wa[sel], wd[sel]}, {6'b0, e});
        $display("cycle %0d: write addr=%h data=%h", cyc, wa[sel], wd[sel]);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    boot_req = 1'b0;
    for (int i = 0; i < 3; i++) wr[i] = 1'b1;
    #1;
    check("rst_rom_addr", {22'b0, rom_addr[sel]}, 32'h0);
    check("rst_valid",    {31'b0, wv[sel]},       32'h0);
    check("rst_waddr",    {22'b0, wa[sel]},       32'h0);
    check("rst_wdata",    {16'b0, wd[sel]},       32'h0);
    check("rst_busy",     {31'b0, busy[sel]},     32'h1);
    check("rst_done",     {31'b0, done[sel]},     32'h0);
    check("rst_hold",     {31'b0, hold[sel]},     32'h1);
    check("rst_csum",     {16'b0, csum[sel]},     32'h0);
    @(negedge clk);
    rst_n       = 1'b1;
    cyc         = 0;
    first_valid = -1;
    done_cyc    = -1;
    hold_fall   = -1;
    hs_cnt      = 0;
    req_cyc     = -1;
    exp_q.delete();
  endtask

  task automatic run_to_done(input int budget, input string tag);
    int n = 0;
    while (done_cyc < 0 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_finished"}, {31'b0, (done_cyc >= 0)}, 32'h1);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int c;
    rst_n    = 1'b0;
    boot_req = 1'b0;
    for (int i = 0; i < 3; i++) wr[i] = 1'b1;
    sel      = 0;
    stall_lo = 1;
    stall_hi = 0;
    req_cyc  = -1;

    // Default length, full throughput
    sel = 0;
    do_reset();
    push_copy(16);
    run_to_done(100, "bl16");
    check("bl16_first_valid", first_valid, 1);
    check("bl16_done_cycle", done_cyc, 17);
    check("bl16_handshakes", hs_cnt, 16);
    check("bl16_checksum", {16'b0, csum[0]}, 32'h0000);
    check("bl16_model_sum", {16'b0, csum[0]}, {16'b0, model_sum(16)});
    check("bl16_last_addr", {22'b0, last_addr}, 32'h00F);
    check("bl16_busy_low", {31'b0, busy[0]}, 32'h0);
    check("bl16_valid_low", {31'b0, wv[0]}, 32'h0);

    // Three-word image
    sel = 1;
    do_reset();
    push_copy(3);
    run_to_done(40, "bl3");
    check("bl3_done_cycle", done_cyc, 4);
    check("bl3_hold_fall", hold_fall, 4);
    check("bl3_checksum", {16'b0, csum[1]}, 32'hA5A6);

    // Back-pressure on cycles 2..4
    sel = 1;
    do_reset();
    stall_lo = 2;
    stall_hi = 4;
    push_copy(3);
    for (int n = 0; n < 40 && done_cyc < 0; n++) begin
      step();
      if (cyc >= 2 && cyc <= 4) begin
        check("bp_valid_held", {31'b0, wv[1]}, 32'h1);
        check("bp_addr_held", {22'b0, wa[1]}, 32'h001);
        check("bp_data_held", {16'b0, wd[1]}, 32'hA5A4);
        check("bp_csum_held", {16'b0, csum[1]}, 32'hA5A5);
      end
    end
    check("bp_finished", {31'b0, (done_cyc >= 0)}, 32'h1);
    check("bp_done_cycle", done_cyc, 7);
    check("bp_checksum", {16'b0, csum[1]}, 32'hA5A6);
    stall_lo = 1;
    stall_hi = 0;

    // Reset asserted after five handshakes
    sel = 0;
    do_reset();
    push_copy(16);
    for (int n = 0; n < 40 && hs_cnt < 5; n++) step();
    check("midrst_reached_5", hs_cnt, 5);
    do_reset();
    push_copy(16);
    run_to_done(100, "midrst");
    check("midrst_first_valid", first_valid, 1);
    check("midrst_done_cycle", done_cyc, 17);
    check("midrst_checksum", {16'b0, csum[0]}, {16'b0, model_sum(16)});

    // BootRequest ignored in FETCH, honoured in DONE
    sel = 1;
    do_reset();
    req_cyc = 2;
    push_copy(3);
    run_to_done(40, "req_fetch");
    check("req_fetch_done_cycle", done_cyc, 4);
    check("req_fetch_handshakes", hs_cnt, 3);
    check("req_fetch_checksum", {16'b0, csum[1]}, 32'hA5A6);
    c = cyc;
    req_cyc = c + 1;
    hs_cnt = 0;
    first_valid = -1;
    push_copy(3);
    step();
    step();
    check("restart_done_low", {31'b0, done[1]}, 32'h0);
    check("restart_busy_high", {31'b0, busy[1]}, 32'h1);
    check("restart_hold_high", {31'b0, hold[1]}, 32'h1);
    check("restart_csum_clear", {16'b0, csum[1]}, 32'h0);
    check("restart_valid_low", {31'b0, wv[1]}, 32'h0);
    done_cyc = -1;
    req_cyc = -1;
    run_to_done(40, "restart");
    check("restart_first_valid", first_valid, c + 3);
    check("restart_done_cycle", done_cyc, c + 6);
    check("restart_handshakes", hs_cnt, 3);
    check("restart_checksum", {16'b0, csum[1]}, 32'hA5A6);

    // Full address space, no wrap
    sel = 2;
    do_reset();
    push_copy(1024);
    run_to_done(1100, "bl1k");
    check("bl1k_done_cycle", done_cyc, 1025);
    check("bl1k_handshakes", hs_cnt, 1024);
    check("bl1k_last_addr", {22'b0, last_addr}, 32'h3FF);
    check("bl1k_rom_addr_nowrap", {22'b0, rom_addr[2]}, 32'h3FF);
    check("bl1k_checksum", {16'b0, csum[2]}, {16'b0, model_sum(1024)});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
